// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the req/gnt/rvalid memory responder.
// Holds the grant FSM states, the response record and the byte-lane merge helper.
package mem_resp_pkg;

    localparam int WORD_WIDTH = 32;
    localparam int BE_WIDTH   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } gnt_state_t;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] rdata;
        logic                  err;
    } resp_t;

    // Merge write data into an existing word, one byte lane per enable bit.
    function automatic logic [WORD_WIDTH-1:0] apply_be(
        input logic [WORD_WIDTH-1:0] old_word,
        input logic [WORD_WIDTH-1:0] wdata,
        input logic [BE_WIDTH-1:0]   be
    );
        logic [WORD_WIDTH-1:0] merged;
        merged = old_word;
        for (int k = 0; k < BE_WIDTH; k++) begin
            if (be[k]) begin
                merged[8*k +: 8] = wdata[8*k +: 8];
            end else begin
                merged[8*k +: 8] = old_word[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Requester-to-memory bus: request/grant handshake plus in-order response channel.
interface data_mem_responder_if
    import mem_resp_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) ();

    logic                  req_i;
    logic [WORD_WIDTH-1:0] addr_i;
    logic                  we_i;
    logic [BE_WIDTH-1:0]   be_i;
    logic [WORD_WIDTH-1:0] wdata_i;
    logic                  gnt_o;
    logic                  rvalid_o;
    logic [WORD_WIDTH-1:0] rdata_o;
    logic                  err_o;

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );

endinterface

// File: rtl/data_mem_responder_resp_delay_line.sv
// Fixed-length shift register carrying {valid, response} from the accept edge to rvalid.
// Async clear drops every in-flight response.
module resp_delay_line
    import mem_resp_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  in_valid,
    input  resp_t in_resp,
    output logic  out_valid,
    output resp_t out_resp
);

    logic  [LATENCY-1:0] valid_r;
    resp_t [LATENCY-1:0] resp_r;

    // Shift one stage per clock; stage 0 loads at the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= {LATENCY{1'b0}};
            resp_r  <= {($bits(resp_r)){1'b0}};
        end else begin
            valid_r[0] <= in_valid;
            resp_r[0]  <= in_resp;
            for (int i = 1; i < LATENCY; i++) begin
                valid_r[i] <= valid_r[i-1];
                resp_r[i]  <= resp_r[i-1];
            end
        end
    end

    assign out_valid = valid_r[LATENCY-1];
    assign out_resp  = resp_r[LATENCY-1];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: word SRAM with byte enables, grant wait states,
// fixed response latency and a cap on outstanding transactions.
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int    WORD_WIDTH      = 32,
    parameter int    DEPTH_WORDS     = 1024,
    parameter int    GNT_WAIT        = 0,
    parameter int    RESP_LATENCY    = 1,
    parameter int    MAX_OUTSTANDING = 2,
    parameter string INIT_FILE       = ""
) (
    input logic                 clk,
    input logic                 rst,
    data_mem_responder_if.slave bus
);

    localparam int AW    = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_OUTSTANDING);
    localparam logic [3:0]       GNT_WAIT_C = 4'(GNT_WAIT);

    logic [WORD_WIDTH-1:0] mem_r [DEPTH_WORDS];

    gnt_state_t       state_r, state_s;
    logic [3:0]       wait_cnt_r, wait_cnt_s;
    logic [CNT_W-1:0] out_cnt_r;
    logic             grant_win_s, slot_free_s, gnt_s, accept_s;
    logic [AW-1:0]    word_idx_s;
    logic             in_range_s;
    resp_t            resp_in_s, resp_out_s;
    logic             valid_out_s;
    logic             unused_s;

    assign word_idx_s = bus.addr_i[AW+1:2];
    assign in_range_s = (bus.addr_i[WORD_WIDTH-1:AW+2] == {(WORD_WIDTH-AW-2){1'b0}});
    assign unused_s   = ^{bus.addr_i[1:0], (INIT_FILE == "")};

    // A response leaving this cycle frees its slot in time for a same-cycle grant.
    assign slot_free_s = (out_cnt_r < MAX_CNT) || valid_out_s;

    // Grant FSM next state; grant_win_s marks cycles where the wait has elapsed.
    always_comb begin
        state_s     = state_r;
        wait_cnt_s  = wait_cnt_r;
        grant_win_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!bus.req_i) begin
                    state_s = IDLE;
                end else if (GNT_WAIT_C == 4'd0) begin
                    grant_win_s = 1'b1;
                    state_s     = READY;
                end else begin
                    state_s    = WAIT;
                    wait_cnt_s = 4'd1;
                end
            end
            WAIT: begin
                if (!bus.req_i) begin
                    state_s    = IDLE;
                    wait_cnt_s = 4'd0;
                end else if (wait_cnt_r == GNT_WAIT_C) begin
                    grant_win_s = 1'b1;
                    state_s     = READY;
                end else begin
                    wait_cnt_s = wait_cnt_r + 4'd1;
                end
            end
            READY: begin
                if (!bus.req_i) begin
                    state_s    = IDLE;
                    wait_cnt_s = 4'd0;
                end else begin
                    grant_win_s = 1'b1;
                end
            end
            default: begin
                state_s    = IDLE;
                wait_cnt_s = 4'd0;
            end
        endcase
        gnt_s = grant_win_s & bus.req_i & slot_free_s;
        if (gnt_s) begin
            state_s    = IDLE;
            wait_cnt_s = 4'd0;
        end else begin
            state_s = state_s;
        end
    end

    assign accept_s  = gnt_s & ~rst;
    assign bus.gnt_o = accept_s;

    // Read data is sampled from the array at the accept edge; writes and misses return zero.
    always_comb begin
        resp_in_s.rdata = {WORD_WIDTH{1'b0}};
        resp_in_s.err   = 1'b0;
        if (accept_s) begin
            resp_in_s.err = ~in_range_s;
            if (!bus.we_i && in_range_s) begin
                resp_in_s.rdata = mem_r[word_idx_s];
            end else begin
                resp_in_s.rdata = {WORD_WIDTH{1'b0}};
            end
        end else begin
            resp_in_s.err = 1'b0;
        end
    end

    // Grant FSM state and wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            wait_cnt_r <= 4'd0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
        end
    end

    // Outstanding count: up on accept, down on rvalid, hold when both coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt_r <= {CNT_W{1'b0}};
        end else begin
            case ({accept_s, valid_out_s})
                2'b10:   out_cnt_r <= out_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   out_cnt_r <= out_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                default: out_cnt_r <= out_cnt_r;
            endcase
        end
    end

    // Byte-enabled array write; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept_s && bus.we_i && in_range_s) begin
            mem_r[word_idx_s] <= apply_be(mem_r[word_idx_s], bus.wdata_i, bus.be_i);
        end
    end

    resp_delay_line #(
        .LATENCY (RESP_LATENCY)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept_s),
        .in_resp   (resp_in_s),
        .out_valid (valid_out_s),
        .out_resp  (resp_out_s)
    );

    assign bus.rvalid_o = valid_out_s;
    assign bus.rdata_o  = resp_out_s.rdata;
    assign bus.err_o    = resp_out_s.err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: three responder configurations share one stimulus driver;
// expected responses are queued at grant time and checked when rvalid appears.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [31:0] addr  = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  be    = 4'h0;
    int          sel   = 0;

    data_mem_responder_if ia ();
    data_mem_responder_if ib ();
    data_mem_responder_if ic ();

    assign ia.req_i = req && (sel == 0);
    assign ib.req_i = req && (sel == 1);
    assign ic.req_i = req && (sel == 2);
    assign ia.addr_i = addr;  assign ib.addr_i = addr;  assign ic.addr_i = addr;
    assign ia.we_i = we;      assign ib.we_i = we;      assign ic.we_i = we;
    assign ia.be_i = be;      assign ib.be_i = be;      assign ic.be_i = be;
    assign ia.wdata_i = wdata; assign ib.wdata_i = wdata; assign ic.wdata_i = wdata;

    data_mem_responder #(.GNT_WAIT(0), .RESP_LATENCY(1), .MAX_OUTSTANDING(2))
        dut_a (.clk(clk), .rst(rst), .bus(ia));
    data_mem_responder #(.GNT_WAIT(3), .RESP_LATENCY(1), .MAX_OUTSTANDING(2))
        dut_b (.clk(clk), .rst(rst), .bus(ib));
    data_mem_responder #(.GNT_WAIT(0), .RESP_LATENCY(3), .MAX_OUTSTANDING(2))
        dut_c (.clk(clk), .rst(rst), .bus(ic));

    logic gnt_s;
    assign gnt_s = (sel == 0) ? ia.gnt_o : (sel == 1) ? ib.gnt_o : ic.gnt_o;

    typedef struct {
        int          d;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model [3][1024];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic int lat(input int d);
        return (d == 2) ? 3 : 1;
    endfunction

    // Response monitor: pops the scoreboard on every rvalid, checks idle outputs otherwise.
    always @(negedge clk) begin
        logic        rv [3];
        logic [31:0] rd [3];
        logic        er [3];
        exp_t        e;
        rv[0] = ia.rvalid_o; rd[0] = ia.rdata_o; er[0] = ia.err_o;
        rv[1] = ib.rvalid_o; rd[1] = ib.rdata_o; er[1] = ib.err_o;
        rv[2] = ic.rvalid_o; rd[2] = ic.rdata_o; er[2] = ic.err_o;
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (rv[d] === 1'b1) begin
                if (q.size() == 0 || q[0].d != d) begin
                    n_bad++;
                    $display("FAIL rvalid_unexpected dut%0d cyc=%0d: got rvalid=1, required 0", d, cyc);
                end else begin
                    e = q.pop_front();
                    if (rd[d] !== e.rdata || er[d] !== e.err || cyc != e.due) begin
                        n_bad++;
                        $display("FAIL response dut%0d: got rdata=%h err=%b cyc=%0d, required rdata=%h err=%b cyc=%0d",
                                 d, rd[d], er[d], cyc, e.rdata, e.err, e.due);
                    end
                end
            end else if (rv[d] !== 1'b0 || rd[d] !== 32'h0 || er[d] !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_outputs dut%0d cyc=%0d: got rvalid=%b rdata=%h err=%b, required 0/0/0",
                         d, cyc, rv[d], rd[d], er[d]);
            end
        end
    end

    // Issue one request and hold it until granted; queue the expected response.
    task automatic issue(input int d, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] wd, output int waits);
        exp_t e;
        logic oor;
        int   idx;
        logic granted;
        sel = d; req = 1'b1; we = w; addr = a; be = b; wdata = wd;
        waits = 0; granted = 1'b0;
        while (!granted && waits <= 40) begin
            @(negedge clk);
            if (gnt_s === 1'b1) begin
                granted = 1'b1;
            end else begin
                waits++;
                @(posedge clk); #1;
            end
        end
        if (!granted) begin
            n_cmp++; n_bad++;
            $display("FAIL grant_timeout dut%0d addr=%h: got no gnt in %0d cycles, required gnt", d, a, waits);
            req = 1'b0;
        end else begin
            oor     = (a[31:12] != 20'h0);
            idx     = int'(a[11:2]);
            e.d     = d;
            e.due   = cyc + lat(d);
            e.err   = oor;
            e.rdata = (w || oor) ? 32'h0 : model[d][idx];
            q.push_back(e);
            if (w && !oor) begin
                for (int k = 0; k < 4; k++) begin
                    if (b[k]) model[d][idx][8*k +: 8] = wd[8*k +: 8];
                end
            end
            @(posedge clk); #1;
            req = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk); #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending responses, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic check_waits(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d wait cycles, required %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        sel = 0; req = 1'b1; addr = 32'h10;
        @(posedge clk); #1;
        n_cmp++;
        if (ia.gnt_o !== 1'b0 || ia.rvalid_o !== 1'b0 || ia.rdata_o !== 32'h0 || ia.err_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_values: got gnt=%b rvalid=%b rdata=%h err=%b, required all 0",
                     ia.gnt_o, ia.rvalid_o, ia.rdata_o, ia.err_o);
        end
        req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int w;
        issue(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, w);
        check_waits("basic_write_gnt", w, 0);
        issue(0, 1'b0, 32'h10, 4'hF, 32'h0, w);
        check_waits("basic_read_gnt", w, 0);
        wait_drain();
    endtask

    task automatic test_byte_enable();
        int w;
        issue(0, 1'b1, 32'h10, 4'b0101, 32'h11223344, w);
        issue(0, 1'b0, 32'h10, 4'hF, 32'h0, w);
        issue(0, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, w);
        issue(0, 1'b0, 32'h10, 4'hF, 32'h0, w);
        issue(0, 1'b1, 32'h14, 4'b1010, 32'hA5A5A5A5, w);
        wait_drain();
    endtask

    task automatic test_out_of_range();
        int w;
        issue(0, 1'b0, 32'h1000, 4'hF, 32'h0, w);
        issue(0, 1'b1, 32'h1010, 4'hF, 32'hCAFEF00D, w);
        issue(0, 1'b1, 32'h80000010, 4'hF, 32'h0BADF00D, w);
        issue(0, 1'b0, 32'h10, 4'hF, 32'h0, w);
        issue(0, 1'b0, 32'h1010, 4'hF, 32'h0, w);
        wait_drain();
    endtask

    task automatic test_gnt_wait();
        int w;
        issue(1, 1'b1, 32'h20, 4'hF, 32'h5A5A1234, w);
        check_waits("gnt_wait_write", w, 3);
        issue(1, 1'b0, 32'h20, 4'hF, 32'h0, w);
        check_waits("gnt_wait_read", w, 3);
        wait_drain();
        sel = 1; req = 1'b1; we = 1'b0; addr = 32'h20;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (gnt_s !== 1'b0) begin
                n_bad++;
                $display("FAIL abort_no_gnt cycle %0d: got gnt=%b, required 0", i, gnt_s);
            end
            @(posedge clk); #1;
        end
        req = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        issue(1, 1'b0, 32'h20, 4'hF, 32'h0, w);
        check_waits("gnt_wait_after_abort", w, 3);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int w;
        int ws [4];
        for (int i = 0; i < 4; i++) begin
            issue(2, 1'b1, 32'(i * 4), 4'hF, 32'h1000_0000 + 32'(i * 32'h0101_0101), w);
        end
        wait_drain();
        for (int i = 0; i < 4; i++) begin
            issue(2, 1'b0, 32'(i * 4), 4'hF, 32'h0, ws[i]);
        end
        check_waits("b2b_read0", ws[0], 0);
        check_waits("b2b_read1", ws[1], 0);
        check_waits("b2b_read2_stall", ws[2], 1);
        check_waits("b2b_read3", ws[3], 0);
        wait_drain();
    endtask

    task automatic test_reset_inflight();
        int w;
        issue(2, 1'b0, 32'h0, 4'hF, 32'h0, w);
        issue(2, 1'b0, 32'h4, 4'hF, 32'h0, w);
        rst = 1'b1;
        q.delete();
        #1;
        n_cmp++;
        if (ic.gnt_o !== 1'b0 || ic.rvalid_o !== 1'b0 || ic.rdata_o !== 32'h0 || ic.err_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_inflight: got gnt=%b rvalid=%b rdata=%h err=%b, required all 0",
                     ic.gnt_o, ic.rvalid_o, ic.rdata_o, ic.err_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        issue(2, 1'b0, 32'h8, 4'hF, 32'h0, w);
        check_waits("post_reset_read", w, 0);
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_enable();
        test_out_of_range();
        test_gnt_wait();
        test_back_to_back();
        test_reset_inflight();
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_responses: got %0d, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the core's req/gnt/rvalid memory protocol. It serves the data interface and can also serve the instruction interface as a read-only port.
- Holds a word-addressed SRAM model with byte-enable writes.
- Inserts a configurable number of grant wait states and a configurable response latency.
- Limits outstanding transactions.
- Used as the memory end in core-level simulation and as the template for the on-chip scratchpad.

Parameters:
- WORD_WIDTH, 32, data/address width in bits.
- DEPTH_WORDS, 1024, number of memory words; must be a power of two.
- GNT_WAIT, 0, cycles req_i must be held before gnt_i may assert (0..15).
- RESP_LATENCY, 1, cycles from accepting edge to rvalid_o (1..8).
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered transactions (1..8).
- INIT_FILE, "", hex file loaded at elaboration; empty means no load.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_i  in  1  request valid; the requester holds it until gnt_o is seen.
- addr_i  in  WORD_WIDTH  byte address; bits [1:0] ignored.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  4  byte enables; bit k selects byte lane k.
- wdata_i  in  WORD_WIDTH  write data.
- gnt_o  out  1  request accepted this cycle (combinational).
- rvalid_o  out  1  response valid for exactly one cycle.
- rdata_o  out  WORD_WIDTH  read data; 0 for write responses.
- err_o  out  1  response-qualified flag: the address was out of range.

Behaviour:
- Reset values (async on rst high):
  - gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0.
  - Wait counter=0, outstanding count=0, delay line cleared.
  - Memory contents are not reset.
- Reset mid-operation discards all in-flight responses. No rvalid_o pulse may appear after reset for pre-reset requests.
- Grant FSM:
  - IDLE:
    - req_i=0: stay in IDLE.
    - req_i=1 and GNT_WAIT=0: go directly to the READY logic.
    - req_i=1 and GNT_WAIT>0: go to WAIT, counter=1.
  - WAIT: counter increments while req_i=1. At counter==GNT_WAIT, go to READY.
  - READY: gnt_o = req_i & (outstanding < MAX_OUTSTANDING). On acceptance (req_i & gnt_o), go to IDLE with counter=0.
  - req_i falling before grant (protocol violation): return to IDLE, counter=0, no transaction.
- Back-to-back: with GNT_WAIT=0 and free slots, one acceptance per cycle is possible.
- Accept edge:
  - Word index = addr_i[log2(DEPTH_WORDS)+1:2].
  - In range = addr_i[WORD_WIDTH-1:log2(DEPTH_WORDS)+2]==0.
  - Write: bytes with be_i[k]=1 are updated at this edge. be_i=0 writes nothing but still produces a response.
  - Read: the word is sampled at this edge, so a read accepted the cycle after a write to the same word returns the new data.
  - Out of range: write dropped; read data=0; err=1 in the response.
- Response timing:
  - A transaction accepted at edge N gives rvalid_o=1 during the cycle after edge N+RESP_LATENCY-1. RESP_LATENCY=1 means rvalid_o in the cycle immediately after the grant cycle.
  - Responses are strictly in order, one per accepted transaction.
  - rdata_o and err_o are valid only while rvalid_o=1; they are 0 otherwise.
- Outstanding counter:
  - +1 on acceptance, -1 on the rvalid_o cycle; unchanged when both happen in the same cycle.
  - Never exceeds MAX_OUTSTANDING.
  - At MAX_OUTSTANDING, gnt_o stays 0 even in READY. It may reassert in the same cycle as the rvalid_o that frees a slot.
- Instruction-port use: we_i is tied to 0. The read path is identical.

Decomposition:
- Package mem_resp_pkg:
  - WORD_WIDTH and BE_WIDTH=4 constants.
  - gnt_state_t enum {IDLE, WAIT, READY}.
  - resp_t struct {rdata, err}.
- Sub-module resp_delay_line: RESP_LATENCY-stage shift register of {valid, resp_t}, with async clear.
- Top level holds the memory array, grant FSM and outstanding counter.

Test Plan:
- Defaults: write 0xDEADBEEF, be=4'hF to 0x10; read 0x10 next cycle -> gnt in the same cycle as req; rvalid one cycle after each grant; rdata=0xDEADBEEF, err=0.
- Byte-enable write be=4'b0101 with 0x11223344 to 0x10 (holding 0xDEADBEEF), then read -> rdata=0xDE22BE44.
- GNT_WAIT=3: hold req read -> gnt asserts in the 4th cycle of req; drop req after 2 cycles -> no gnt, no rvalid, FSM back to IDLE.
- RESP_LATENCY=3, MAX_OUTSTANDING=2, four reads issued back-to-back -> grants in cycles 0 and 1, stall until the first rvalid in cycle 3, then gnt in cycle 3; rvalids in order with correct data.
- Out-of-range read at address 0x1000 (DEPTH_WORDS=1024) -> rvalid with rdata=0, err=1; out-of-range write leaves the whole memory unchanged.
- Assert rst while 2 responses are in flight -> all outputs 0 immediately, no rvalid afterwards; the next request is served normally.
